// File: rtl/pkt_filter_pkg.sv
// Shared types and constants for the pkt_filter store-and-forward packet filter.
package pkt_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    SEND
  } state_e;

  localparam int unsigned STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cnt,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, cnt} + {{(STAT_W-1){1'b0}}, inc};
    return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/pkt_filter_buf.sv
// pkt_buf_ram: simple dual-port packet buffer, one write port, one read port with registered read data.
module pkt_buf_ram
  import pkt_filter_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [1 << AW];
  logic [DWIDTH-1:0] rdata_q;

  // Read data holds while re_i is low so the output stage can stall on it.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_filter.sv
// pkt_filter: buffers a whole packet and forwards it only if MIN_PKT_LEN <= length <= MAX_PKT_LEN.
// Define PKT_FILTER_STATS_EN to add the drop_cnt_o / pkt_cnt_o statistics outputs.
module pkt_filter
  import pkt_filter_pkg::*;
#(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned MAX_PKT_LEN = 13,
  parameter int unsigned MIN_PKT_LEN = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
`ifdef PKT_FILTER_STATS_EN
  output logic [STAT_W-1:0] drop_cnt_o,
  output logic [STAT_W-1:0] pkt_cnt_o,
`endif
  input  logic              src_ready_i
);

  localparam int unsigned    CW      = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CW-1:0]  LEN_MAX = CW'(MAX_PKT_LEN);

  function automatic logic legal_len(input int unsigned l);
    return (l >= MIN_PKT_LEN) && (l <= MAX_PKT_LEN);
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     rd_addr_q, rd_addr_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic              rd_vld_q, rd_vld_d;
  logic              snk_ready_q, snk_ready_d;
  logic              src_valid_q, src_valid_d;
  logic              src_sop_q, src_sop_d;
  logic              src_eop_q, src_eop_d;
  logic [DWIDTH-1:0] src_data_q, src_data_d;

  logic              we, re;
  logic [CW-1:0]     waddr;
  logic [DWIDTH-1:0] rdata;
  logic              accept, xfer, out_free;
  logic [1:0]        drop_ev;
  logic              pkt_ev;

  assign accept   = snk_valid_i && snk_ready_q;
  assign xfer     = src_valid_q && src_ready_i;
  assign out_free = !src_valid_q || src_ready_i;

  pkt_buf_ram #(
    .DWIDTH (DWIDTH),
    .AW     (CW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (snk_data_i),
    .re_i    (re),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_addr_d   = rd_addr_q;
    rd_idx_d    = rd_idx_q;
    rd_vld_d    = rd_vld_q;
    src_valid_d = src_valid_q;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;
    src_data_d  = src_data_q;
    we          = 1'b0;
    waddr       = len_q;
    re          = 1'b0;
    drop_ev     = '0;
    pkt_ev      = 1'b0;

    case (state_q)
      IDLE, RECV, DROP: begin
        if (accept) begin
          if (snk_startofpacket_i) begin
            we    = 1'b1;
            waddr = '0;
            if (state_q == RECV) drop_ev = drop_ev + 2'd1;
            if (!snk_endofpacket_i) begin
              state_d = RECV;
              len_d   = CW'(1);
            end else if (legal_len(1)) begin
              state_d = SEND;
              len_d   = CW'(1);
            end else begin
              state_d = IDLE;
              len_d   = '0;
              drop_ev = drop_ev + 2'd1;
            end
          end else if (state_q == RECV) begin
            if (snk_endofpacket_i) begin
              if (legal_len(32'(len_q) + 32'd1)) begin
                we      = 1'b1;
                state_d = SEND;
                len_d   = len_q + CW'(1);
              end else begin
                state_d = IDLE;
                len_d   = '0;
                drop_ev = drop_ev + 2'd1;
              end
            end else if (len_q == LEN_MAX) begin
              state_d = DROP;
              len_d   = '0;
              drop_ev = drop_ev + 2'd1;
            end else begin
              we    = 1'b1;
              len_d = len_q + CW'(1);
            end
          end else if (state_q == DROP && snk_endofpacket_i) begin
            state_d = IDLE;
          end
        end
      end

      SEND: begin
        // Two-stage read pipeline: RAM read register feeds the output register;
        // a new read is issued only when the RAM register is free or being drained.
        if (rd_addr_q < len_q && (!rd_vld_q || out_free)) begin
          re        = 1'b1;
          rd_idx_d  = rd_addr_q;
          rd_addr_d = rd_addr_q + CW'(1);
          rd_vld_d  = 1'b1;
        end else if (out_free) begin
          rd_vld_d = 1'b0;
        end

        if (xfer) begin
          src_valid_d = 1'b0;
          src_sop_d   = 1'b0;
          src_eop_d   = 1'b0;
          if (src_eop_q) begin
            state_d   = IDLE;
            len_d     = '0;
            rd_addr_d = '0;
            rd_vld_d  = 1'b0;
            pkt_ev    = 1'b1;
          end
        end

        if (rd_vld_q && out_free) begin
          src_valid_d = 1'b1;
          src_data_d  = rdata;
          src_sop_d   = (rd_idx_q == '0);
          src_eop_d   = (rd_idx_q == len_q - CW'(1));
        end
      end

      default: state_d = IDLE;
    endcase

    snk_ready_d = (state_d != SEND);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rd_addr_q   <= '0;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      snk_ready_q <= 1'b0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      rd_idx_q    <= rd_idx_d;
      rd_vld_q    <= rd_vld_d;
      snk_ready_q <= snk_ready_d;
      src_valid_q <= src_valid_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      src_data_q  <= src_data_d;
    end
  end

  assign snk_ready_o         = snk_ready_q;
  assign src_valid_o         = src_valid_q;
  assign src_startofpacket_o = src_sop_q;
  assign src_endofpacket_o   = src_eop_q;
  assign src_data_o          = src_data_q;

`ifdef PKT_FILTER_STATS_EN
  logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [STAT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  assign drop_cnt_d = sat_add(drop_cnt_q, drop_ev);
  assign pkt_cnt_d  = sat_add(pkt_cnt_q, {1'b0, pkt_ev});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign pkt_cnt_o  = pkt_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{drop_ev, pkt_ev};
`endif

endmodule

// File: tb/tb_pkt_filter.sv
// Randomized self-checking bench for pkt_filter against a packet-level reference model.
module tb_pkt_filter;

  localparam int unsigned MINL = 2;
  localparam int unsigned MAXL = 13;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } oword_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] snk_data = '0;
  logic        snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0;
  logic        src_ready = 1'b1;
  logic        snk_ready_o, src_sop_o, src_eop_o, src_valid_o;
  logic [15:0] src_data_o;

  logic [15:0] d1_data = '0;
  logic        d1_sop = 1'b0, d1_eop = 1'b0, d1_valid = 1'b0;
  logic        d1_src_ready = 1'b1;
  logic        d1_snk_ready, d1_src_sop, d1_src_eop, d1_src_valid;
  logic [15:0] d1_src_data;
`ifdef PKT_FILTER_STATS_EN
  logic [15:0] drop_cnt, pkt_cnt, d1_drop_cnt, d1_pkt_cnt;
`endif

  pkt_filter #(.DWIDTH(16), .MAX_PKT_LEN(MAXL), .MIN_PKT_LEN(MINL)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .snk_data_i          (snk_data),
    .snk_startofpacket_i (snk_sop),
    .snk_endofpacket_i   (snk_eop),
    .snk_valid_i         (snk_valid),
    .snk_ready_o         (snk_ready_o),
    .src_data_o          (src_data_o),
    .src_startofpacket_o (src_sop_o),
    .src_endofpacket_o   (src_eop_o),
    .src_valid_o         (src_valid_o),
`ifdef PKT_FILTER_STATS_EN
    .drop_cnt_o          (drop_cnt),
    .pkt_cnt_o           (pkt_cnt),
`endif
    .src_ready_i         (src_ready)
  );

  pkt_filter #(.DWIDTH(16), .MAX_PKT_LEN(MAXL), .MIN_PKT_LEN(1)) dut1 (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .snk_data_i          (d1_data),
    .snk_startofpacket_i (d1_sop),
    .snk_endofpacket_i   (d1_eop),
    .snk_valid_i         (d1_valid),
    .snk_ready_o         (d1_snk_ready),
    .src_data_o          (d1_src_data),
    .src_startofpacket_o (d1_src_sop),
    .src_endofpacket_o   (d1_src_eop),
    .src_valid_o         (d1_src_valid),
`ifdef PKT_FILTER_STATS_EN
    .drop_cnt_o          (d1_drop_cnt),
    .pkt_cnt_o           (d1_pkt_cnt),
`endif
    .src_ready_i         (d1_src_ready)
  );

  initial forever #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: packet-level view of the rules
  oword_t      exp_q[$];
  logic [15:0] cur_q[$];
  logic [15:0] pkt_q[$];
  bit          in_pkt = 0, busy = 0, armed = 0, prev_stall = 0, gap_en = 0;
  oword_t      prev_w;
  int          lat_cnt = 0;
  int unsigned m_drop = 0, m_pkt = 0;
  int          rdy_mode = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      in_pkt = 0; busy = 0; armed = 0; prev_stall = 0; lat_cnt = 0;
      m_drop = 0; m_pkt = 0;
    end else if (!armed) begin
      check("rdy_before_edge", 32'(snk_ready_o), 32'(0));
      armed = 1;
    end else begin
      check("snk_ready", 32'(snk_ready_o), 32'(!busy));
      if (prev_stall)
        check("stall_hold", 32'({src_valid_o, src_sop_o, src_eop_o, src_data_o}),
              32'({1'b1, prev_w}));
      if (lat_cnt == 1 || lat_cnt == 2) begin
        check("lat_early", 32'(src_valid_o), 32'(0));
        lat_cnt++;
      end else if (lat_cnt == 3) begin
        check("lat_rise", 32'(src_valid_o), 32'(1));
        lat_cnt = 0;
      end

      if (src_valid_o && src_ready) begin
        if (exp_q.size() == 0) begin
          check("out_extra", 32'(exp_q.size()), 32'(1));
        end else begin
          oword_t w;
          w = exp_q.pop_front();
          check("out_word", 32'({src_sop_o, src_eop_o, src_data_o}), 32'(w));
          if (w.eop) begin
            busy = 0;
            m_pkt++;
          end
        end
      end
      prev_stall = src_valid_o && !src_ready;
      prev_w     = {src_sop_o, src_eop_o, src_data_o};

      if (snk_valid && snk_ready_o) begin
        if (snk_sop) begin
          if (in_pkt) m_drop++;
          cur_q.delete();
          in_pkt = 1;
        end
        if (in_pkt) begin
          cur_q.push_back(snk_data);
          if (snk_eop) begin
            in_pkt = 0;
            if (cur_q.size() >= MINL && cur_q.size() <= MAXL) begin
              for (int i = 0; i < cur_q.size(); i++)
                exp_q.push_back({i == 0, i == cur_q.size() - 1, cur_q[i]});
              busy    = 1;
              lat_cnt = 1;
            end else begin
              m_drop++;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       src_ready = 1'b1;
      1:       src_ready = 1'($urandom_range(0, 1));
      default: src_ready = ~src_ready;
    endcase
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(src_valid_o), 32'(0));
    check("rst_sop", 32'(src_sop_o), 32'(0));
    check("rst_eop", 32'(src_eop_o), 32'(0));
    check("rst_data", 32'(src_data_o), 32'(0));
    check("rst_ready", 32'(snk_ready_o), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic put_word(input logic [15:0] d, input logic s, input logic e);
    int unsigned n = 0;
    logic acc = 1'b0;
    snk_data = d; snk_sop = s; snk_eop = e; snk_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = snk_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'(1));
  endtask

  task automatic send_pkt(input bit no_sop, input bit no_eop, input int mid_sop);
    for (int i = 0; i < pkt_q.size(); i++) begin
      put_word(pkt_q[i], ((i == 0) && !no_sop) || (i == mid_sop),
               (i == pkt_q.size() - 1) && !no_eop);
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
`ifdef PKT_FILTER_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_min1();
    int unsigned n_out = 0;
    d1_data = 16'hABCD; d1_sop = 1'b1; d1_eop = 1'b1; d1_valid = 1'b1;
    @(negedge clk);
    check("d1_ready", 32'(d1_snk_ready), 32'(1));
    @(posedge clk);
    #1;
    d1_valid = 1'b0; d1_sop = 1'b0; d1_eop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d1_src_valid) begin
        n_out++;
        check("d1_word", 32'({d1_src_sop, d1_src_eop, d1_src_data}), 32'({2'b11, 16'hABCD}));
      end
    end
    check("d1_count", 32'(n_out), 32'(1));
`ifdef PKT_FILTER_STATS_EN
    check("d1_pkt_cnt", 32'(d1_pkt_cnt), 32'(1));
    check("d1_drop_cnt", 32'(d1_drop_cnt), 32'(0));
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    #2;
    do_reset();

    // 5,3,9 with ready held high
    rdy_mode = 0;
    pkt_q = '{16'd5, 16'd3, 16'd9};
    send_pkt(0, 0, -1);
    wait_idle();

    // oversize 14-word packet, then a legal 2-word packet
    pkt_q.delete();
    for (int i = 0; i < 14; i++) pkt_q.push_back(16'(16'h0E00 + i));
    send_pkt(0, 0, -1);
    pkt_q = '{16'h1111, 16'h2222};
    send_pkt(0, 0, -1);
    wait_idle();

    // single-word packet: dropped here, forwarded by the MIN_PKT_LEN=1 instance
    pkt_q = '{16'h00AA};
    send_pkt(0, 0, -1);
    wait_idle();
    test_min1();

    // maximum-length packet with toggling downstream ready
    rdy_mode = 2;
    pkt_q.delete();
    for (int i = 0; i < 13; i++) pkt_q.push_back(16'(16'hD000 + i));
    send_pkt(0, 0, -1);
    wait_idle();
    rdy_mode = 0;

    // A1,A2 abandoned by B1 sop, B2 eop
    pkt_q = '{16'hA001, 16'hA002};
    send_pkt(0, 1, -1);
    pkt_q = '{16'hB001, 16'hB002};
    send_pkt(0, 0, -1);
    wait_idle();

    // reset while word 2 is on the output
    pkt_q.delete();
    for (int i = 0; i < 6; i++) pkt_q.push_back(16'(16'hC000 + i));
    send_pkt(0, 0, -1);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (src_valid_o && src_data_o == 16'hC002) hit = 1;
    end
    check("rst_reach_word2", 32'(hit), 32'(1));
    #1;
    do_reset();
    pkt_q = '{16'h7001, 16'h7002, 16'h7003};
    send_pkt(0, 0, -1);
    wait_idle();

    // randomized traffic with malformed packets and random backpressure
    gap_en = 1;
    for (int p = 0; p < 60; p++) begin
      int unsigned len, f;
      len = $urandom_range(1, 16);
      f   = $urandom_range(0, 9);
      rdy_mode = int'($urandom_range(0, 2));
      pkt_q.delete();
      for (int i = 0; i < int'(len); i++) pkt_q.push_back(16'($urandom));
      send_pkt(f == 7, f == 8, (f == 9 && len > 2) ? int'($urandom_range(1, len - 1)) : -1);
    end
    rdy_mode = 1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_filter.md
PKT_FILTER -- requirements
Module: pkt_filter

Interface
REQ-001 Parameter DWIDTH, default 16: data word width in bits.
REQ-002 Parameter MAX_PKT_LEN, default 13: longest legal packet in words; must match the downstream sorter.
REQ-003 Parameter MIN_PKT_LEN, default 2: shortest legal packet in words; 1 <= MIN_PKT_LEN <= MAX_PKT_LEN.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 snk_data_i  in  DWIDTH  upstream data word.
REQ-007 snk_startofpacket_i  in  1  first word of packet.
REQ-008 snk_endofpacket_i  in  1  last word of packet.
REQ-009 snk_valid_i  in  1  upstream word valid.
REQ-010 snk_ready_o  out  1  block accepts a word this cycle.
REQ-011 src_data_o  out  DWIDTH  data word to the sorter.
REQ-012 src_startofpacket_o  out  1  first word of forwarded packet.
REQ-013 src_endofpacket_o  out  1  last word of forwarded packet.
REQ-014 src_valid_o  out  1  output word valid.
REQ-015 src_ready_i  in  1  sorter accepts the word.

Function
REQ-016 A word is accepted on a cycle with snk_valid_i && snk_ready_o; an output word is transferred on a cycle with src_valid_o && src_ready_i.
REQ-017 The block shall be store-and-forward: it buffers a whole packet and forwards it only if its length L satisfies MIN_PKT_LEN <= L <= MAX_PKT_LEN; otherwise it drops the whole packet.
REQ-018 FSM states: IDLE, RECV, DROP, SEND; all state and output registers are clocked.
REQ-019 IDLE: snk_ready_o=1; an accepted word with sop writes buffer[0] and sets len=1, then goes to RECV; if eop is also set, the packet is complete (len=1) and is judged per REQ-017. An accepted word without sop is discarded and the FSM stays in IDLE.
REQ-020 RECV: snk_ready_o=1; each accepted word writes buffer[len], and len increments.
REQ-021 RECV, accepted sop: the current packet is abandoned; the word restarts the buffer at index 0 with len=1.
REQ-022 RECV, accepted non-eop word when len==MAX_PKT_LEN: go to DROP.
REQ-023 RECV, accepted eop: if the final length is legal, go to SEND; otherwise go to IDLE.
REQ-024 DROP: snk_ready_o=1; words are discarded until an accepted eop, then go to IDLE. An accepted sop in DROP restarts as in REQ-021.
REQ-025 SEND: snk_ready_o=0; words 0..len-1 are output in order.
REQ-026 SEND: src_startofpacket_o=1 only with word 0, and src_endofpacket_o=1 only with word len-1; for len==1 both are 1.
REQ-027 While src_valid_o=1 and src_ready_i=0, src_data_o, sop and eop shall be held stable.
REQ-028 Latency: src_valid_o shall rise exactly 2 cycles after the accepting edge of a legal eop; with src_ready_i held at 1, one word is transferred per cycle.
REQ-029 After the eop word is transferred: src_valid_o=0 next cycle, go to IDLE, snk_ready_o=1 next cycle.
REQ-030 len and the address counters shall be $clog2(MAX_PKT_LEN+1) bits wide and shall never wrap.

Reset
REQ-031 On rst_n_i=0, immediately: state=IDLE, len=0, snk_ready_o=0, src_valid_o=0, src_startofpacket_o=0, src_endofpacket_o=0, src_data_o=0.
REQ-032 snk_ready_o=1 from the first clock edge after deassertion.
REQ-033 A reset mid-packet or mid-SEND discards the buffered packet; no partial output follows.

Configuration
REQ-034 Macro PKT_FILTER_STATS_EN, when defined, adds two outputs:
- drop_cnt_o  out  16: count of dropped or abandoned packets.
- pkt_cnt_o  out  16: count of forwarded packets.
Both increment once per event, saturate at 16'hFFFF and reset to 0.
REQ-035 Without PKT_FILTER_STATS_EN, these ports and counters shall not exist and behaviour is otherwise identical.

Structure
REQ-036 Package pkt_filter_pkg shall hold the FSM state enum type and the counter width constant.
REQ-037 Buffer storage shall be a sub-module pkt_buf_ram: simple dual-port, one write port, one read port, 1-cycle registered read.

Verification
REQ-038 Packet 5,3,9 (L=3), src_ready_i=1 -> output 5,3,9; sop on 5, eop on 9; valid rises 2 cycles after eop.
REQ-039 14-word packet -> no output; snk_ready_o stays 1; next legal 2-word packet forwarded intact.
REQ-040 1-word packet (sop&eop), MIN_PKT_LEN=2 -> dropped; with MIN_PKT_LEN=1 -> one output word with sop=eop=1.
REQ-041 13-word packet, src_ready_i toggling 1/0 -> 13 words in order, data stable during stalls, snk_ready_o=0 until the eop transfer.
REQ-042 sop mid-packet (A1,A2,B1 sop,B2 eop) -> only B1,B2 output; with PKT_FILTER_STATS_EN, drop_cnt_o=1 and pkt_cnt_o=1.
REQ-043 rst_n_i pulsed during SEND word 2 -> outputs 0 immediately; no further words; next packet forwarded normally.
